// File: rtl/fpu_share_arbiter.sv
// Round-robin arbiter that shares one combinational FP32 unit between NREQ requesters.
// Optional build macro FPU_ARB_CANON_NAN_EN canonicalises NaN results to 32'h7fc00000.
module fpu_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*32-1:0] req_c,
  input  logic [NREQ*5-1:0]  req_rm,
  input  logic [4:0]         frm,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_o,
  output logic [4:0]         rsp_flags,
  output logic [4:0]         fflags,
  input  logic               fflags_clr,
  output logic [31:0]        fpu_a,
  output logic [31:0]        fpu_b,
  output logic [31:0]        fpu_c,
  output logic [4:0]         fpu_rm,
  input  logic [31:0]        fpu_o,
  input  logic               fpu_nv,
  input  logic               fpu_dz,
  input  logic               fpu_of,
  input  logic               fpu_uf,
  input  logic               fpu_nx
);

  localparam logic [31:0] QNAN = 32'h7fc0_0000;
  localparam logic [4:0]  RM_RNE = 5'b00001;
  localparam logic [4:0]  FLAG_NV = 5'b10000;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic           any_valid;
  logic           rsp_fire;
  logic           grant;
  logic [4:0]     win_rm;
  logic [4:0]     eff_rm;
  logic           rm_legal;
  logic [31:0]    fpu_res;
  int             idx;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    any_valid = 1'b0;
    win       = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        win       = IDW'(idx);
      end
    end
  end

  assign rsp_fire = (state == RESP) && rsp_ready;
  // A new grant is only taken when no operation is outstanding or the held response leaves this cycle.
  assign grant    = !rst && any_valid && ((state == IDLE) || rsp_fire);
  assign win_rm   = req_rm[int'(win)*5 +: 5];
  assign eff_rm   = (win_rm == 5'd0) ? frm : win_rm;
  assign rm_legal = (eff_rm != 5'd0) && ((eff_rm & (eff_rm - 5'd1)) == 5'd0);

`ifdef FPU_ARB_CANON_NAN_EN
  assign fpu_res = ((fpu_o[30:23] == 8'hff) && (fpu_o[22:0] != 23'd0)) ? QNAN : fpu_o;
`else
  assign fpu_res = fpu_o;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = rm_legal ? ISSUE : RESP;
      ISSUE:   state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (grant) state_nxt = rm_legal ? ISSUE : RESP;
          else       state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) req_ready[k] = grant && (win == IDW'(k));
    rsp_valid = (state == RESP);
  end

  // NOTE: only control and output registers are reset; there is no storage array here needing a reset sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      rsp_id    <= '0;
      rsp_o     <= '0;
      rsp_flags <= '0;
      fflags    <= '0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      fpu_c     <= '0;
      fpu_rm    <= RM_RNE;
    end else begin
      if (grant) begin
        ptr    <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
        rsp_id <= win;
        if (rm_legal) begin
          fpu_a  <= req_a[int'(win)*32 +: 32];
          fpu_b  <= req_b[int'(win)*32 +: 32];
          fpu_c  <= req_c[int'(win)*32 +: 32];
          fpu_rm <= eff_rm;
        end else begin
          // Malformed rounding mode never reaches the FPU; answer with an invalid-operation NaN.
          rsp_o     <= QNAN;
          rsp_flags <= FLAG_NV;
        end
      end
      if (state == ISSUE) begin
        rsp_o     <= fpu_res;
        rsp_flags <= {fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx};
      end
      if (rsp_fire)        fflags <= (fflags_clr ? 5'd0 : fflags) | rsp_flags;
      else if (fflags_clr) fflags <= 5'd0;
    end
  end

endmodule
